cr_huf_comp_sc_short: RTL
=========================

# cr_huf_comp_sc_short

Short-alphabet symbol counter for the Huffman compressor. It accumulates per-symbol frequencies for one block from an incoming symbol stream. At end-of-block it drains the histogram as packed groups of up to four (symbol, count) pairs to the insert-sort stage, which reads them with `is_sc_short_rd`. It sits directly upstream of the short-tree insertion sort and clears its histogram as it drains.

## Interface
Parameters:
- `NUM_SYM`, 64, short alphabet size; multiple of 4.
- `DAT_WIDTH`, 6, symbol width; equals log2(`NUM_SYM`).
- `CNT_WIDTH`, 16, frequency counter width.
- `SEQID_WIDTH`, 4, sequence-id width.

Ports:
- `clk` in 1: clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_vld` in 1: input symbol valid.
- `in_sym` in `DAT_WIDTH`: symbol to count.
- `in_eob` in 1: beat is the last of the block; its symbol is counted.
- `in_seq_id` in `SEQID_WIDTH`: block sequence id; sampled on the eob beat.
- `in_rdy` out 1: beat accepted when `in_vld & in_rdy`.
- `sc_is_short_vld` out 4: thermometer slot-valid mask.
- `sc_is_short_sym0..3` out `DAT_WIDTH` each: slot symbols.
- `sc_is_short_cnt0..3` out `CNT_WIDTH` each: slot counts.
- `sc_is_short_seq_id` out `SEQID_WIDTH`: id of the draining block.
- `sc_is_short_eob` out 1: final word of the block.
- `is_sc_short_rd` in 1: pop of the current output word.

## Operation
- State machine has two states: ACCUM and DRAIN. Histogram is `NUM_SYM` x `CNT_WIDTH` flops. A scan pointer `ptr` steps in windows of 4.
- **ACCUM:**
  - `in_rdy`=1.
  - An accepted beat increments `hist[in_sym]`.
  - An accepted beat with `in_eob`=1 captures `in_seq_id`, sets `ptr`=0 and moves to DRAIN.
- **DRAIN:**
  - `in_rdy`=0.
  - The output register is "full" when `|sc_is_short_vld | sc_is_short_eob`.
  - In each cycle where the output register is empty or being popped, the block evaluates window `hist[ptr..ptr+3]`:
    - Nonzero entries are packed into the lowest slots in ascending symbol order, and the mask is thermometer-coded (0001, 0011, 0111, 1111).
    - All four window entries are zeroed.
    - `ptr` advances by 4.
  - A non-final window with all four entries zero loads nothing; the output stays empty and `ptr` still advances.
  - The final window (`ptr`=`NUM_SYM`-4) always loads a word with `eob`=1, even if its mask is 0000.
  - A pop of the eob word returns the block to ACCUM.
- `is_sc_short_rd` while the output register is empty is ignored.
- A pop and a load in the same cycle are legal and give full throughput.
- Unused slots drive symbol 0 and count 0.

## Timing
- Reset:
  - state ACCUM; histogram, `ptr`, and all output ports are 0.
  - `in_rdy`=0 during reset and 1 in the first cycle after reset deasserts.
  - A reset mid-drain discards the block and clears every histogram entry.
- Increments are visible in `hist` one cycle after acceptance.
- Back-to-back increments of the same symbol are not lost; each beat adds exactly 1.
- The eob beat is accepted in cycle T. DRAIN starts at T+1, and the first window loads at T+1, so its word is visible at T+2.
- With `is_sc_short_rd` held at 1, the drain takes `NUM_SYM`/4 cycles: 16 cycles at the defaults.
- A pop of the eob word in cycle P gives `in_rdy`=1 at P+1.
- The output word is held stable while full and not popped.

## Configuration
- `CR_HUF_COMP_SC_SHORT_SAT_EN`
  - Defined: a counter at 2^`CNT_WIDTH`-1 stays there on further increments.
  - Undefined: counters wrap modulo 2^`CNT_WIDTH`.

## Test plan
- Stream syms 1,1,5,63(eob), seq_id 3, rd held at 1. Exactly three words:
  - vld 0001, sym0=1, cnt0=2;
  - vld 0001, sym0=5, cnt0=1;
  - vld 0001, sym0=63, cnt0=1, eob=1, seq_id=3.
- Syms 8,9,11,11(eob). The window 8-11 word is vld 0111 with syms 8,9,11 and cnts 1,1,2. It is followed by a separate final word: vld 0000, eob=1.
- Backpressure: hold rd=0 for 10 cycles after the first word. The word stays stable and `ptr` does not advance; after rd rises the remaining words come out unchanged.
- Send 65536 beats of sym 2 plus an eob beat on sym 0. Required cnt for sym 2:
  - with `CR_HUF_COMP_SC_SHORT_SAT_EN` defined, 65535;
  - undefined, 0, so sym 2 is omitted from the output.
- Assert `rst` mid-drain, then send sym 4 with eob. Output is vld 0001, sym0=4, cnt0=1, with no counts left over from the aborted block.
- Back-to-back blocks: the second block is only accepted once `in_rdy` returns. Its counts are independent of the first block, since every histogram entry reads 0 after the drain.

Source files
------------

// File: rtl/cr_huf_comp_sc_short.sv
// Purpose: per-block short-alphabet symbol histogram, drained as packed groups of up to four (sym, cnt) pairs.
// Latency: an eob beat accepted in cycle T gives the first drain word at T+2, and the drain takes NUM_SYM/4 cycles when the sink keeps popping.
// Backpressure: in_rdy is low while draining, and a full output word is held until is_sc_short_rd pops it.
// Option: define CR_HUF_COMP_SC_SHORT_SAT_EN to saturate the counters; otherwise they wrap.
module cr_huf_comp_sc_short #(
  parameter int NUM_SYM     = 64,
  parameter int DAT_WIDTH   = 6,
  parameter int CNT_WIDTH   = 16,
  parameter int SEQID_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_vld,
  input  logic [DAT_WIDTH-1:0]   in_sym,
  input  logic                   in_eob,
  input  logic [SEQID_WIDTH-1:0] in_seq_id,
  output logic                   in_rdy,
  output logic [3:0]             sc_is_short_vld,
  output logic [DAT_WIDTH-1:0]   sc_is_short_sym0,
  output logic [DAT_WIDTH-1:0]   sc_is_short_sym1,
  output logic [DAT_WIDTH-1:0]   sc_is_short_sym2,
  output logic [DAT_WIDTH-1:0]   sc_is_short_sym3,
  output logic [CNT_WIDTH-1:0]   sc_is_short_cnt0,
  output logic [CNT_WIDTH-1:0]   sc_is_short_cnt1,
  output logic [CNT_WIDTH-1:0]   sc_is_short_cnt2,
  output logic [CNT_WIDTH-1:0]   sc_is_short_cnt3,
  output logic [SEQID_WIDTH-1:0] sc_is_short_seq_id,
  output logic                   sc_is_short_eob,
  input  logic                   is_sc_short_rd
);

  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  typedef struct packed {
    logic [DAT_WIDTH-1:0] sym;
    logic [CNT_WIDTH-1:0] cnt;
  } slot_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   hist [NUM_SYM];
  logic [DAT_WIDTH-1:0]   ptr;
  logic [SEQID_WIDTH-1:0] seq_q;

  logic [3:0]             out_vld;
  logic                   out_eob;
  slot_t                  out_slot [4];

  logic                   acc_beat;
  logic                   out_full;
  logic                   load_en;
  logic                   pop_eob;
  logic                   last_win;
  logic [CNT_WIDTH-1:0]   inc_cnt;

  logic [DAT_WIDTH-1:0]   win_sym [4];
  logic [CNT_WIDTH-1:0]   win_cnt [4];
  slot_t                  pk_slot [4];
  logic [3:0]             pk_vld;
  logic [2:0]             pk_num;

  // State register: synchronous reset returns to accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: the eob beat starts the drain, and popping the eob word ends it.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (acc_beat && in_eob) state_nxt = DRAIN;
      DRAIN:   if (pop_eob)            state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // FSM outputs: input handshake, window load and final pop qualifiers.
  // Once the eob word is sitting in the output register, no further windows are scanned.
  always_comb begin
    in_rdy   = (state == ACCUM) && !rst;
    acc_beat = in_vld && in_rdy;
    out_full = (|out_vld) || out_eob;
    load_en  = (state == DRAIN) && !out_eob && (!out_full || is_sc_short_rd);
    pop_eob  = (state == DRAIN) && out_eob && is_sc_short_rd;
  end

  // Counter increment for the symbol being accepted.
  always_comb begin
`ifdef CR_HUF_COMP_SC_SHORT_SAT_EN
    inc_cnt = (hist[in_sym] == '1) ? hist[in_sym] : hist[in_sym] + CNT_WIDTH'(1);
`else
    inc_cnt = hist[in_sym] + CNT_WIDTH'(1);
`endif
  end

  // Window pack: move the nonzero entries of hist[ptr..ptr+3] into the lowest slots in ascending order.
  always_comb begin
    pk_num = 3'd0;
    for (int i = 0; i < 4; i++) begin
      win_sym[i] = ptr + DAT_WIDTH'(i);
      win_cnt[i] = hist[win_sym[i]];
      pk_slot[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      if (win_cnt[i] != '0) begin
        pk_slot[pk_num[1:0]].sym = win_sym[i];
        pk_slot[pk_num[1:0]].cnt = win_cnt[i];
        pk_num = pk_num + 3'd1;
      end
    end
    case (pk_num)
      3'd0:    pk_vld = 4'b0000;
      3'd1:    pk_vld = 4'b0001;
      3'd2:    pk_vld = 4'b0011;
      3'd3:    pk_vld = 4'b0111;
      default: pk_vld = 4'b1111;
    endcase
  end

  assign last_win = (ptr == DAT_WIDTH'(NUM_SYM - 4));

  // Histogram: count accepted beats, and clear each window as it is drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SYM; i++) hist[i] <= '0;
    end else begin
      if (acc_beat) hist[in_sym] <= inc_cnt;
      if (load_en) begin
        for (int i = 0; i < 4; i++) hist[win_sym[i]] <= '0;
      end
    end
  end

  // Scan pointer: restarts at the eob beat and steps one window per load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (acc_beat && in_eob) begin
      ptr <= '0;
    end else if (load_en) begin
      ptr <= ptr + DAT_WIDTH'(4);
    end
  end

  // Sequence id of the block being drained, captured on its eob beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q <= '0;
    end else if (acc_beat && in_eob) begin
      seq_q <= in_seq_id;
    end
  end

  // Output word register.
  // An all-zero window that is not the last one loads an empty word, so the register stays free for the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= '0;
      out_eob <= 1'b0;
      for (int i = 0; i < 4; i++) out_slot[i] <= '0;
    end else if (load_en) begin
      out_vld <= pk_vld;
      out_eob <= last_win;
      for (int i = 0; i < 4; i++) out_slot[i] <= pk_slot[i];
    end else if (pop_eob) begin
      out_vld <= '0;
      out_eob <= 1'b0;
      for (int i = 0; i < 4; i++) out_slot[i] <= '0;
    end
  end

  assign sc_is_short_vld    = out_vld;
  assign sc_is_short_eob    = out_eob;
  assign sc_is_short_seq_id = seq_q;
  assign sc_is_short_sym0   = out_slot[0].sym;
  assign sc_is_short_sym1   = out_slot[1].sym;
  assign sc_is_short_sym2   = out_slot[2].sym;
  assign sc_is_short_sym3   = out_slot[3].sym;
  assign sc_is_short_cnt0   = out_slot[0].cnt;
  assign sc_is_short_cnt1   = out_slot[1].cnt;
  assign sc_is_short_cnt2   = out_slot[2].cnt;
  assign sc_is_short_cnt3   = out_slot[3].cnt;

endmodule
